// File: rtl/fifo_byte_packer.sv
// fifo_byte_packer: drains DATA_WIDTH entries from an async-FIFO read port and
// packs PACK_RATIO of them into one wide word on a valid/ready output.
// Lane 0 (LSBs) holds the oldest entry. Partial words leave on a flush pulse.
// Optional feature: define PACK_TIMEOUT_EN to auto-flush a partial word after
// TIMEOUT_CYCLES idle cycles.
module fifo_byte_packer #(
   parameter int DATA_WIDTH     = 8,
   parameter int PACK_RATIO     = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                           rd_clk,
   input  logic                           reset,
   input  logic                           fifo_empty,
   output logic                           fifo_rd_en,
   input  logic [DATA_WIDTH-1:0]          fifo_rd_data,
   input  logic                           flush,
   output logic [DATA_WIDTH*PACK_RATIO-1:0] out_data,
   output logic [PACK_RATIO-1:0]          out_keep,
   output logic                           out_valid,
   input  logic                           out_ready
);

   localparam int CW = $clog2(PACK_RATIO + 1);
   localparam int WW = DATA_WIDTH * PACK_RATIO;

   typedef enum logic [0:0] {
      S_FILL  = 1'b0,
      S_FLUSH = 1'b1
   } state_t;

   state_t          r_state;
   logic [CW-1:0]   r_lane_cnt;
   logic            r_inflight;
   logic            r_rd_req;
   logic [WW-1:0]   r_acc;
   logic [WW-1:0]   r_out_data;
   logic [PACK_RATIO-1:0] r_out_keep;
   logic            r_out_valid;

   logic [WW-1:0]   w_acc_m;
   logic [CW-1:0]   w_cnt_m;
   logic [PACK_RATIO-1:0] w_keep;
   logic            w_out_free;
   logic            w_flush_trig;
   logic            w_emit;
   logic [CW-1:0]   w_cnt_after;
   logic [CW:0]     w_pending;
   state_t          w_state_nxt;
   logic            w_rd_req_nxt;
   logic            w_timeout;

   // The read request is registered; gating it with the live empty flag keeps
   // back-to-back reads at full rate without ever popping an empty FIFO.
   assign fifo_rd_en = r_rd_req & ~fifo_empty;

   assign out_data  = r_out_data;
   assign out_keep  = r_out_keep;
   assign out_valid = r_out_valid;

   // Merge the entry arriving this cycle into the accumulator and lane count.
   always_comb begin
      w_acc_m = r_acc;
      w_keep  = '0;
      for (int i = 0; i < PACK_RATIO; i++) begin
         if (r_inflight && (r_lane_cnt == CW'(i))) begin
            w_acc_m[i*DATA_WIDTH +: DATA_WIDTH] = fifo_rd_data;
         end else begin
            w_acc_m[i*DATA_WIDTH +: DATA_WIDTH] = r_acc[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
      w_cnt_m = r_lane_cnt + {{(CW-1){1'b0}}, r_inflight};
      for (int i = 0; i < PACK_RATIO; i++) begin
         w_keep[i] = (CW'(i) < w_cnt_m);
      end
   end

   // Emit decision, next state and next read request.
   always_comb begin
      w_out_free   = ~r_out_valid | out_ready;
      w_flush_trig = (r_state == S_FILL) && (flush || w_timeout);
      w_emit       = w_out_free &&
                     ((w_cnt_m == CW'(PACK_RATIO)) ||
                      ((r_state == S_FLUSH) && (w_cnt_m != '0)));
      if (w_emit) begin
         w_cnt_after = '0;
      end else begin
         w_cnt_after = w_cnt_m;
      end
      case (r_state)
         S_FILL: begin
            if (w_flush_trig) begin
               w_state_nxt = S_FLUSH;
            end else begin
               w_state_nxt = S_FILL;
            end
         end
         S_FLUSH: begin
            // No reads are issued here, so after this cycle nothing is in flight.
            if ((w_cnt_m == '0) || w_emit) begin
               w_state_nxt = S_FILL;
            end else begin
               w_state_nxt = S_FLUSH;
            end
         end
         default: w_state_nxt = S_FILL;
      endcase
      // Lanes held plus the read being issued now must leave room for one more.
      w_pending    = {1'b0, w_cnt_after} + {{CW{1'b0}}, fifo_rd_en};
      w_rd_req_nxt = (w_state_nxt == S_FILL) && (w_pending < (CW+1)'(PACK_RATIO));
   end

`ifdef PACK_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] r_idle_cnt;
   logic          w_idle;

   assign w_idle    = (r_lane_cnt != '0) && (r_state == S_FILL) && !r_inflight;
   assign w_timeout = w_idle && (r_idle_cnt == TW'(TIMEOUT_CYCLES - 1));

   // Idle counter: runs while a partial word waits with no new entries.
   always_ff @(posedge rd_clk) begin
      if (reset) begin
         r_idle_cnt <= '0;
      end else if (r_inflight || w_emit || w_timeout) begin
         r_idle_cnt <= '0;
      end else if (w_idle) begin
         r_idle_cnt <= r_idle_cnt + TW'(1);
      end else begin
         r_idle_cnt <= r_idle_cnt;
      end
   end
`else
   // No idle counter in this build; the parameter only shapes the interface.
   assign w_timeout = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

   // Packer state, accumulator and registered output word.
   always_ff @(posedge rd_clk) begin
      if (reset) begin
         r_state     <= S_FILL;
         r_lane_cnt  <= '0;
         r_inflight  <= 1'b0;
         r_rd_req    <= 1'b0;
         r_acc       <= '0;
         r_out_data  <= '0;
         r_out_keep  <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_lane_cnt <= w_cnt_after;
         r_inflight <= fifo_rd_en;
         r_rd_req   <= w_rd_req_nxt;
         if (w_emit) begin
            r_acc       <= '0;
            r_out_data  <= w_acc_m;
            r_out_keep  <= w_keep;
            r_out_valid <= 1'b1;
         end else begin
            r_acc <= w_acc_m;
            if (out_ready) begin
               r_out_valid <= 1'b0;
            end else begin
               r_out_valid <= r_out_valid;
            end
         end
      end
   end

endmodule

// File: tb/tb_fifo_byte_packer.sv
// Scoreboard bench for fifo_byte_packer: a simple FIFO model feeds the DUT,
// expected words are queued as stimulus is issued, a monitor compares beats.
module tb_fifo_byte_packer;

   localparam int TMO = 16;

   logic        rd_clk;
   logic        reset;
   logic        fifo_empty;
   logic        fifo_rd_en;
   logic [7:0]  fifo_rd_data;
   logic        flush;
   logic [31:0] out_data;
   logic [3:0]  out_keep;
   logic        out_valid;
   logic        out_ready;

   logic [7:0]  mem [0:255];
   int          wr_cnt;
   int          rd_cnt;
   logic [35:0] exp_q [$];
   int          n_cmp;
   int          n_bad;
   int          beats;
   logic        hold_v;
   logic [35:0] hold_word;

   fifo_byte_packer #(.DATA_WIDTH(8), .PACK_RATIO(4), .TIMEOUT_CYCLES(TMO)) dut (
      .rd_clk       (rd_clk),
      .reset        (reset),
      .fifo_empty   (fifo_empty),
      .fifo_rd_en   (fifo_rd_en),
      .fifo_rd_data (fifo_rd_data),
      .flush        (flush),
      .out_data     (out_data),
      .out_keep     (out_keep),
      .out_valid    (out_valid),
      .out_ready    (out_ready)
   );

   initial rd_clk = 1'b0;
   always #5 rd_clk = ~rd_clk;

   assign fifo_empty = (wr_cnt == rd_cnt);

   // FIFO model read side: data appears one cycle after the read strobe.
   initial begin
      rd_cnt       = 0;
      fifo_rd_data = 8'h00;
   end
   always @(posedge rd_clk) begin
      if (fifo_rd_en) begin
         fifo_rd_data <= mem[rd_cnt % 256];
         rd_cnt       <= rd_cnt + 1;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: compare every accepted beat, hold stability, no read when empty.
   always @(negedge rd_clk) begin
      if (reset) begin
         hold_v = 1'b0;
      end else begin
         if (fifo_rd_en) check("no_read_when_empty", 64'(fifo_empty), 64'h0);
         if (hold_v) check("hold_stable", {27'h0, out_valid, out_keep, out_data}, {27'h0, 1'b1, hold_word});
         if (out_valid && out_ready) begin
            beats++;
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_beat: got keep=%h data=%h expected no beat", out_keep, out_data);
            end else begin
               check("beat", {28'h0, out_keep, out_data}, {28'h0, exp_q.pop_front()});
            end
         end
         hold_v    = out_valid && !out_ready;
         hold_word = {out_keep, out_data};
      end
   end

   task automatic push_entry(input logic [7:0] b);
      @(posedge rd_clk); #1;
      mem[wr_cnt % 256] = b;
      wr_cnt = wr_cnt + 1;
   endtask

   task automatic expect_word(input logic [31:0] d, input logic [3:0] k);
      exp_q.push_back({k, d});
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge rd_clk);
      #1;
   endtask

   task automatic pulse_flush();
      @(posedge rd_clk); #1;
      flush = 1'b1;
      @(posedge rd_clk); #1;
      flush = 1'b0;
   endtask

   task automatic drain(input int max_cycles);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < max_cycles) begin
         @(posedge rd_clk);
         k++;
      end
      @(negedge rd_clk);
      check("drain_timeout", 64'(exp_q.size()), 64'h0);
   endtask

   initial begin
      int b0;
      int r0;
      n_cmp = 0; n_bad = 0; beats = 0; wr_cnt = 0;
      hold_v = 1'b0; hold_word = '0;
      reset = 1'b1; flush = 1'b0; out_ready = 1'b1;

      // Reset state
      repeat (2) @(posedge rd_clk);
      @(negedge rd_clk);
      check("rst_out_valid", 64'(out_valid), 64'h0);
      check("rst_rd_en", 64'(fifo_rd_en), 64'h0);
      check("rst_out_data", 64'(out_data), 64'h0);
      check("rst_out_keep", 64'(out_keep), 64'h0);
      @(posedge rd_clk); #1;
      reset = 1'b0;
      idle(2);

      // Full word, single beat
      b0 = beats;
      expect_word(32'hDDCCBBAA, 4'hF);
      push_entry(8'hAA); push_entry(8'hBB); push_entry(8'hCC); push_entry(8'hDD);
      drain(30);
      idle(5);
      check("t1_beat_count", 64'(beats - b0), 64'h1);

      // Partial word on flush
      expect_word(32'h00CCBBAA, 4'h7);
      push_entry(8'hAA); push_entry(8'hBB); push_entry(8'hCC);
      idle(5);
      pulse_flush();
      drain(30);

      // Backpressure: first word held, accumulator fills, reads stall
      out_ready = 1'b0;
      r0 = rd_cnt;
      expect_word(32'h04030201, 4'hF);
      expect_word(32'h08070605, 4'hF);
      expect_word(32'h0C0B0A09, 4'hF);
      for (int i = 1; i <= 12; i++) push_entry(8'(i));
      idle(10);
      @(negedge rd_clk);
      check("t3_reads_stalled", 64'(rd_cnt - r0), 64'h8);
      check("t3_held_data", 64'(out_data), 64'h04030201);
      @(posedge rd_clk); #1;
      out_ready = 1'b1;
      drain(40);

      // Flush with nothing buffered
      b0 = beats;
      pulse_flush();
      idle(10);
      check("t4_no_beat", 64'(beats - b0), 64'h0);

      // Reset mid-accumulation discards partial lanes
      push_entry(8'h55); push_entry(8'h66);
      idle(6);
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
      @(negedge rd_clk);
      check("t5_valid_after_reset", 64'(out_valid), 64'h0);
      b0 = beats;
      expect_word(32'h14131211, 4'hF);
      push_entry(8'h11); push_entry(8'h12); push_entry(8'h13); push_entry(8'h14);
      drain(30);
      idle(5);
      check("t5_beat_count", 64'(beats - b0), 64'h1);

      // Idle timeout behaviour
`ifdef PACK_TIMEOUT_EN
      expect_word(32'h000000AA, 4'h1);
      push_entry(8'hAA);
      drain(TMO + 40);
`else
      b0 = beats;
      push_entry(8'hAA);
      idle(100);
      check("t6_no_autoflush", 64'(beats - b0), 64'h0);
      expect_word(32'h000000AA, 4'h1);
      pulse_flush();
      drain(30);
`endif

      idle(5);
      check("end_queue_empty", 64'(exp_q.size()), 64'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
